// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the E stage; mult/div results computed at start, committed after a fixed cycle count.
// Latency: mult/multu MULT_CYCLES edges, div/divu DIV_CYCLES edges, mthi/mtlo 1 edge.
// Backpressure: busy stays high while an op is in flight; start during busy is ignored.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load, commit;
    logic [31:0]   res_hi, res_lo;
    logic          div_zero;

    logic [31:0] calc_hi, calc_lo;
    logic        is_md_op;

    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;

    assign is_md_op = (mdop == OP_MULT) || (mdop == OP_MULTU) ||
                      (mdop == OP_DIV)  || (mdop == OP_DIVU);

    assign prod_s = $signed(A) * $signed(B);
    assign prod_u = {32'h0, A} * {32'h0, B};

    // Signed divide on magnitudes so the most-negative / -1 case stays well defined.
    assign a_neg  = (mdop == OP_DIV) && A[31];
    assign b_neg  = (mdop == OP_DIV) && B[31];
    assign a_mag  = a_neg ? (32'h0 - A) : A;
    assign b_mag  = b_neg ? (32'h0 - B) : B;
    assign b_safe = (b_mag == 32'h0) ? 32'h1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;

    always_comb begin
        calc_hi = 32'h0;
        calc_lo = 32'h0;
        case (mdop)
            OP_MULT:  {calc_hi, calc_lo} = prod_s;
            OP_MULTU: {calc_hi, calc_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                calc_lo = (a_neg ^ b_neg) ? (32'h0 - q_mag) : q_mag;
                calc_hi = a_neg ? (32'h0 - r_mag) : r_mag;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_md_op) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = ((mdop == OP_MULT) || (mdop == OP_MULTU)) ?
                                CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end
            end
            RUN: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            res_hi   <= 32'h0;
            res_lo   <= 32'h0;
            div_zero <= 1'b0;
            HI       <= 32'h0;
            LO       <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                res_hi   <= calc_hi;
                res_lo   <= calc_lo;
                div_zero <= ((mdop == OP_DIV) || (mdop == OP_DIVU)) && (B == 32'h0);
            end
            if (commit && !div_zero) begin
                HI <= res_hi;
                LO <= res_lo;
            end
            // Direct writes only land when no op is in flight.
            if (state == IDLE && start && mdop == OP_MTHI) HI <= A;
            if (state == IDLE && start && mdop == OP_MTLO) LO <= A;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: behavioural HI/LO model checked every cycle plus literal expectations.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mdop = 3'd0;
    logic [31:0] A = 32'h0;
    logic [31:0] B = 32'h0;
    logic        busy;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_fail = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdop(mdop),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Behavioural model: result computed with wide integer arithmetic, committed at a target cycle number.
    logic [31:0] m_hi = 0, m_lo = 0, m_rhi = 0, m_rlo = 0;
    logic        m_pend = 0, m_dz = 0;
    int          cyc = 0, m_done = 0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_pend = 0; m_dz = 0;
        end else begin
            cyc++;
            if (m_pend) begin
                if (start && mdop >= 3'd1 && mdop <= 3'd6)
                    $display("note: protocol violation, start while busy (mdop=%0d) at %0t", mdop, $time);
                if (cyc == m_done) begin
                    m_pend = 0;
                    if (!m_dz) begin m_hi = m_rhi; m_lo = m_rlo; end
                end
            end else if (start) begin
                longint sa, sb, q, r;
                logic [63:0] p;
                case (mdop)
                    3'd1: begin
                        sa = $signed(A); sb = $signed(B); p = sa * sb;
                        m_rhi = p[63:32]; m_rlo = p[31:0];
                        m_pend = 1; m_dz = 0; m_done = cyc + 5;
                    end
                    3'd2: begin
                        p = {32'h0, A} * {32'h0, B};
                        m_rhi = p[63:32]; m_rlo = p[31:0];
                        m_pend = 1; m_dz = 0; m_done = cyc + 5;
                    end
                    3'd3, 3'd4: begin
                        if (mdop == 3'd3) begin sa = $signed(A); sb = $signed(B); end
                        else begin sa = longint'({32'h0, A}); sb = longint'({32'h0, B}); end
                        m_dz = (B == 0);
                        if (!m_dz) begin
                            q = sa / sb; r = sa % sb;
                            m_rlo = q[31:0]; m_rhi = r[31:0];
                        end
                        m_pend = 1; m_done = cyc + 10;
                    end
                    3'd5: m_hi = A;
                    3'd6: m_lo = A;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("model_busy", {31'h0, busy}, {31'h0, m_pend});
        check("model_hi", HI, m_hi);
        check("model_lo", LO, m_lo);
    end

    // Call at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; mdop = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; mdop = 3'd0;
    endtask

    task automatic run_count(output int n);
        n = 0;
        while (busy && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("reset_hi", HI, 32'h0);
        check("reset_lo", LO, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);

        issue(3'd1, 32'hFFFFFFFD, 32'd5);
        check("mult_hi_old", HI, 32'h0);
        check("mult_lo_old", LO, 32'h0);
        run_count(n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFF1);

        issue(3'd2, 32'hFFFFFFFF, 32'd2);
        run_count(n);
        check("multu_cycles", n, 32'd5);
        check("multu_hi", HI, 32'h00000001);
        check("multu_lo", LO, 32'hFFFFFFFE);

        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        run_count(n);
        check("div_cycles", n, 32'd10);
        check("div_lo", LO, 32'hFFFFFFFD);
        check("div_hi", HI, 32'hFFFFFFFF);

        issue(3'd4, 32'd7, 32'd3);
        run_count(n);
        check("divu_lo", LO, 32'd2);
        check("divu_hi", HI, 32'd1);

        issue(3'd7, 32'h55, 32'h66);
        check("nop_busy", {31'h0, busy}, 32'h0);
        check("nop_hi", HI, 32'd1);
        check("nop_lo", LO, 32'd2);

        issue(3'd5, 32'h12345678, 32'h0);
        check("mthi_busy", {31'h0, busy}, 32'h0);
        check("mthi_hi", HI, 32'h12345678);
        issue(3'd6, 32'h9ABCDEF0, 32'h0);
        check("mtlo_busy", {31'h0, busy}, 32'h0);
        check("mtlo_lo", LO, 32'h9ABCDEF0);
        issue(3'd4, 32'd99, 32'd0);
        run_count(n);
        check("dz_cycles", n, 32'd10);
        check("dz_hi", HI, 32'h12345678);
        check("dz_lo", LO, 32'h9ABCDEF0);

        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_hi", HI, 32'h0);
        check("arst_lo", LO, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("arst_nolate_hi", HI, 32'h0);
        check("arst_nolate_lo", LO, 32'h0);
        issue(3'd1, 32'd6, 32'd7);
        run_count(n);
        check("post_rst_cycles", n, 32'd5);
        check("post_rst_lo", LO, 32'd42);
        check("post_rst_hi", HI, 32'd0);

        issue(3'd1, 32'h00010000, 32'h00010000);
        issue(3'd5, 32'h0000DEAD, 32'h0);
        check("b2b_busy", {31'h0, busy}, 32'd1);
        run_count(n);
        check("b2b_rem_cycles", n, 32'd4);
        check("b2b_hi", HI, 32'd1);
        check("b2b_lo", LO, 32'd0);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("b2b_accept", {31'h0, busy}, 32'd1);
        run_count(n);
        check("b2b2_cycles", n, 32'd5);
        check("b2b2_hi", HI, 32'd0);
        check("b2b2_lo", LO, 32'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
